// File: rtl/warp_fetch_scheduler.sv
// Per-warp fetch controller: tracks PC, active mask and state of every warp,
// accepts warp launches, picks one READY warp per cycle round-robin into a
// single registered fetch slot, and re-arms or retires warps on decoder feedback.
module warp_fetch_scheduler #(
  parameter int PcWidth   = 32,
  parameter int NumWarps  = 8,
  parameter int WarpWidth = 32,
  parameter int WidWidth  = (NumWarps > 1) ? $clog2(NumWarps) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 launch_valid_i,
  output logic                 launch_ready_o,
  input  logic [PcWidth-1:0]   launch_pc_i,
  input  logic [WarpWidth-1:0] launch_act_mask_i,
  input  logic                 ic_ready_i,
  output logic                 fe_valid_o,
  output logic [PcWidth-1:0]   fe_pc_o,
  output logic [WarpWidth-1:0] fe_act_mask_o,
  output logic [WidWidth-1:0]  fe_warp_id_o,
  input  logic                 dec_decoded_i,
  input  logic                 dec_stop_warp_i,
  input  logic [WidWidth-1:0]  dec_decoded_warp_id_i,
  input  logic [PcWidth-1:0]   dec_decoded_next_pc_i,
  output logic [NumWarps-1:0]  warp_active_o,
  output logic                 all_idle_o
);

  typedef enum logic [1:0] {
    ST_INACTIVE = 2'd0,
    ST_READY    = 2'd1,
    ST_WAITING  = 2'd2
  } warp_state_e;

  warp_state_e            st_q   [NumWarps];
  warp_state_e            st_d   [NumWarps];
  logic [PcWidth-1:0]     pc_q   [NumWarps];
  logic [WarpWidth-1:0]   mask_q [NumWarps];
  logic [WidWidth-1:0]    rr_q;
  logic [NumWarps-1:0]    seen_q;

  logic                   fe_valid_q;
  logic [PcWidth-1:0]     fe_pc_q;
  logic [WarpWidth-1:0]   fe_mask_q;
  logic [WidWidth-1:0]    fe_wid_q;

  logic                   launch_ready;
  logic [WidWidth-1:0]    launch_idx;
  logic                   launch_fire;
  logic                   grant_vld;
  logic [WidWidth-1:0]    grant_idx;
  logic                   load_en;
  logic [NumWarps-1:0]    fb_hit;

  // Lowest-index INACTIVE warp is the launch target; scan high to low so the lowest wins.
  always_comb begin
    launch_ready = 1'b0;
    launch_idx   = '0;
    for (int w = NumWarps - 1; w >= 0; w--) begin
      if (st_q[w] == ST_INACTIVE) begin
        launch_ready = 1'b1;
        launch_idx   = WidWidth'(w);
      end
    end
  end

  // Round-robin pick among READY warps starting at rr_q; scan backwards so the first hit wins.
  always_comb begin
    int                  cand;
    logic [WidWidth-1:0] cand_idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = NumWarps - 1; i >= 0; i--) begin
      cand = int'(rr_q) + i;
      if (cand >= NumWarps) cand = cand - NumWarps;
      cand_idx = WidWidth'(cand);
      if (st_q[cand_idx] == ST_READY) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  assign launch_fire = launch_valid_i && launch_ready;
  // The slot may take a new warp when it is empty or is being handed to the I-cache now.
  assign load_en     = !fe_valid_q || ic_ready_i;

  // Per-warp next state; launch, grant and feedback act on mutually exclusive states.
  always_comb begin
    for (int w = 0; w < NumWarps; w++) begin
      st_d[w]   = st_q[w];
      fb_hit[w] = dec_decoded_i && (dec_decoded_warp_id_i == WidWidth'(w)) &&
                  (st_q[w] == ST_WAITING);
      if (launch_fire && (launch_idx == WidWidth'(w))) begin
        st_d[w] = ST_READY;
      end else if (load_en && grant_vld && (grant_idx == WidWidth'(w))) begin
        st_d[w] = ST_WAITING;
      end else if (fb_hit[w]) begin
        st_d[w] = dec_stop_warp_i ? ST_INACTIVE : ST_READY;
      end
    end
  end

  // Warp state, PC and mask registers.
  always_ff @(posedge clk_i) begin
    for (int w = 0; w < NumWarps; w++) begin
      if (!rst_ni) begin
        st_q[w]   <= ST_INACTIVE;
        pc_q[w]   <= '0;
        mask_q[w] <= '0;
      end else begin
        st_q[w] <= st_d[w];
        if (launch_fire && (launch_idx == WidWidth'(w))) begin
          pc_q[w]   <= launch_pc_i;
          mask_q[w] <= launch_act_mask_i;
        end else if (fb_hit[w] && !dec_stop_warp_i) begin
          pc_q[w] <= dec_decoded_next_pc_i;
        end
      end
    end
  end

  // Fetch slot and round-robin pointer; the slot holds steady while the I-cache stalls.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fe_valid_q <= 1'b0;
      fe_pc_q    <= '0;
      fe_mask_q  <= '0;
      fe_wid_q   <= '0;
      rr_q       <= '0;
    end else if (load_en) begin
      fe_valid_q <= grant_vld;
      if (grant_vld) begin
        fe_pc_q   <= pc_q[grant_idx];
        fe_mask_q <= mask_q[grant_idx];
        fe_wid_q  <= grant_idx;
        rr_q      <= (int'(grant_idx) == NumWarps - 1) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  // Remembers which warps have been launched since reset, so that feedback still in flight
  // across a reset (aimed at a never-launched warp) is tolerated by the protocol check.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      seen_q <= '0;
    end else if (launch_fire) begin
      seen_q[launch_idx] <= 1'b1;
    end
  end

  assign fe_valid_o     = fe_valid_q;
  assign fe_pc_o        = fe_pc_q;
  assign fe_act_mask_o  = fe_mask_q;
  assign fe_warp_id_o   = fe_wid_q;
  assign launch_ready_o = launch_ready;

  // Activity summary straight from registered state.
  always_comb begin
    for (int w = 0; w < NumWarps; w++) begin
      warp_active_o[w] = (st_q[w] != ST_INACTIVE);
    end
  end

  assign all_idle_o = !(|warp_active_o) && !fe_valid_q;

  a_feedback_target_waiting : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    dec_decoded_i |-> ((st_q[dec_decoded_warp_id_i] == ST_WAITING) ||
                       ((st_q[dec_decoded_warp_id_i] == ST_INACTIVE) &&
                        !seen_q[dec_decoded_warp_id_i])));

endmodule

// File: tb/tb_warp_fetch_scheduler.sv
// Directed bench for warp_fetch_scheduler: launch, round-robin fetch order,
// backpressure, warp stop/relaunch and reset while busy.
module tb_warp_fetch_scheduler;

  localparam int PcWidth   = 32;
  localparam int NumWarps  = 8;
  localparam int WarpWidth = 32;
  localparam int WidWidth  = 3;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic                 launch_valid_i;
  logic                 launch_ready_o;
  logic [PcWidth-1:0]   launch_pc_i;
  logic [WarpWidth-1:0] launch_act_mask_i;
  logic                 ic_ready_i;
  logic                 fe_valid_o;
  logic [PcWidth-1:0]   fe_pc_o;
  logic [WarpWidth-1:0] fe_act_mask_o;
  logic [WidWidth-1:0]  fe_warp_id_o;
  logic                 dec_decoded_i;
  logic                 dec_stop_warp_i;
  logic [WidWidth-1:0]  dec_decoded_warp_id_i;
  logic [PcWidth-1:0]   dec_decoded_next_pc_i;
  logic [NumWarps-1:0]  warp_active_o;
  logic                 all_idle_o;

  int n_cmp = 0;
  int n_bad = 0;

  warp_fetch_scheduler #(
    .PcWidth  (PcWidth),
    .NumWarps (NumWarps),
    .WarpWidth(WarpWidth)
  ) dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .launch_valid_i       (launch_valid_i),
    .launch_ready_o       (launch_ready_o),
    .launch_pc_i          (launch_pc_i),
    .launch_act_mask_i    (launch_act_mask_i),
    .ic_ready_i           (ic_ready_i),
    .fe_valid_o           (fe_valid_o),
    .fe_pc_o              (fe_pc_o),
    .fe_act_mask_o        (fe_act_mask_o),
    .fe_warp_id_o         (fe_warp_id_o),
    .dec_decoded_i        (dec_decoded_i),
    .dec_stop_warp_i      (dec_stop_warp_i),
    .dec_decoded_warp_id_i(dec_decoded_warp_id_i),
    .dec_decoded_next_pc_i(dec_decoded_next_pc_i),
    .warp_active_o        (warp_active_o),
    .all_idle_o           (all_idle_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    launch_valid_i = 1'b0;
    dec_decoded_i = 1'b0;
    dec_stop_warp_i = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic chk_fe(input string tag, input logic [2:0] id, input logic [31:0] pc);
    chk({tag, "_vld"}, 64'(fe_valid_o), 64'd1);
    chk({tag, "_id"}, 64'(fe_warp_id_o), 64'(id));
    chk({tag, "_pc"}, 64'(fe_pc_o), 64'(pc));
  endtask

  logic [2:0]  exp_id [7] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0};
  logic [31:0] exp_pc [7] = '{32'h10, 32'h20, 32'h30, 32'h11, 32'h21, 32'h31, 32'h12};

  initial begin
    launch_pc_i = '0;
    launch_act_mask_i = '0;
    ic_ready_i = 1'b1;
    dec_decoded_warp_id_i = '0;
    dec_decoded_next_pc_i = '0;
    do_reset();

    // Reset state, then idle for 10 cycles.
    chk("rst_fe_vld", 64'(fe_valid_o), 64'd0);
    chk("rst_fe_pc", 64'(fe_pc_o), 64'd0);
    chk("rst_fe_mask", 64'(fe_act_mask_o), 64'd0);
    chk("rst_fe_id", 64'(fe_warp_id_o), 64'd0);
    chk("rst_active", 64'(warp_active_o), 64'd0);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_fe_vld", 64'(fe_valid_o), 64'd0);
      chk("idle_lready", 64'(launch_ready_o), 64'd1);
      chk("idle_all_idle", 64'(all_idle_o), 64'd1);
    end

    // Single warp launch, fetch, re-arm, fetch again, stop.
    launch_valid_i = 1'b1;
    launch_pc_i = 32'h100;
    launch_act_mask_i = 32'hFFFF_FFFF;
    tick();
    launch_valid_i = 1'b0;
    chk("t2_vld_early", 64'(fe_valid_o), 64'd0);
    chk("t2_active", 64'(warp_active_o), 64'h01);
    chk("t2_all_idle", 64'(all_idle_o), 64'd0);
    tick();
    chk_fe("t2_f0", 3'd0, 32'h100);
    chk("t2_mask", 64'(fe_act_mask_o), 64'hFFFF_FFFF);
    dec_decoded_i = 1'b1;
    dec_decoded_warp_id_i = 3'd0;
    dec_decoded_next_pc_i = 32'h101;
    tick();
    dec_decoded_i = 1'b0;
    chk("t2_vld_gap", 64'(fe_valid_o), 64'd0);
    tick();
    chk_fe("t2_f1", 3'd0, 32'h101);
    dec_decoded_i = 1'b1;
    dec_stop_warp_i = 1'b1;
    tick();
    dec_decoded_i = 1'b0;
    dec_stop_warp_i = 1'b0;
    chk("t2_stop_active", 64'(warp_active_o), 64'h00);
    chk("t2_stop_idle", 64'(all_idle_o), 64'd1);

    // Three warps with immediate feedback: round-robin order 0,1,2,0,1,2,0.
    do_reset();
    launch_valid_i = 1'b1;
    launch_act_mask_i = 32'h0000_00FF;
    launch_pc_i = 32'h10;
    tick();
    chk("t3_vld_early", 64'(fe_valid_o), 64'd0);
    for (int k = 0; k < 7; k++) begin
      launch_valid_i = (k < 2);
      launch_pc_i = (k == 0) ? 32'h20 : 32'h30;
      tick();
      chk_fe($sformatf("t3_f%0d", k), exp_id[k], exp_pc[k]);
      dec_decoded_i = 1'b1;
      dec_decoded_warp_id_i = exp_id[k];
      dec_decoded_next_pc_i = exp_pc[k] + 32'd1;
    end
    dec_decoded_i = 1'b0;
    launch_valid_i = 1'b0;

    // Backpressure: slot frozen while the I-cache stalls with two READY warps behind it.
    do_reset();
    ic_ready_i = 1'b0;
    launch_valid_i = 1'b1;
    launch_pc_i = 32'h40;
    tick();
    launch_pc_i = 32'h50;
    tick();
    launch_pc_i = 32'h60;
    for (int c = 0; c < 5; c++) begin
      tick();
      launch_valid_i = 1'b0;
      chk_fe($sformatf("t4_hold%0d", c), 3'd0, 32'h40);
    end
    chk("t4_active", 64'(warp_active_o), 64'h07);
    ic_ready_i = 1'b1;
    tick();
    chk_fe("t4_rel1", 3'd1, 32'h50);
    tick();
    chk_fe("t4_rel2", 3'd2, 32'h60);
    tick();
    chk("t4_drained", 64'(fe_valid_o), 64'd0);

    // Fill every slot, stop warp 1, relaunch into the freed slot.
    do_reset();
    launch_valid_i = 1'b1;
    launch_act_mask_i = 32'hFFFF_FFFF;
    for (int w = 0; w < NumWarps; w++) begin
      launch_pc_i = 32'h200 + 32'(w);
      chk($sformatf("t5_lready%0d", w), 64'(launch_ready_o), 64'd1);
      tick();
    end
    chk("t5_full_lready", 64'(launch_ready_o), 64'd0);
    chk("t5_full_active", 64'(warp_active_o), 64'hFF);
    launch_pc_i = 32'h300;
    launch_act_mask_i = 32'h0F0F_0F0F;
    tick();
    chk("t5_blocked_lready", 64'(launch_ready_o), 64'd0);
    chk_fe("t5_last", 3'd7, 32'h207);
    dec_decoded_i = 1'b1;
    dec_stop_warp_i = 1'b1;
    dec_decoded_warp_id_i = 3'd1;
    tick();
    dec_decoded_i = 1'b0;
    dec_stop_warp_i = 1'b0;
    chk("t5_stop_active", 64'(warp_active_o), 64'hFD);
    chk("t5_stop_lready", 64'(launch_ready_o), 64'd1);
    chk("t5_stop_novld", 64'(fe_valid_o), 64'd0);
    tick();
    launch_valid_i = 1'b0;
    chk("t5_relaunch_active", 64'(warp_active_o), 64'hFF);
    chk("t5_relaunch_lready", 64'(launch_ready_o), 64'd0);
    chk("t5_relaunch_novld", 64'(fe_valid_o), 64'd0);
    tick();
    chk_fe("t5_refetch", 3'd1, 32'h300);
    chk("t5_refetch_mask", 64'(fe_act_mask_o), 64'h0F0F_0F0F);

    // Reset while a fetch is pending and warps are WAITING; late feedback must be ignored.
    ic_ready_i = 1'b0;
    tick();
    chk("t6_pending", 64'(fe_valid_o), 64'd1);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    chk("t6_fe_vld", 64'(fe_valid_o), 64'd0);
    chk("t6_fe_pc", 64'(fe_pc_o), 64'd0);
    chk("t6_fe_mask", 64'(fe_act_mask_o), 64'd0);
    chk("t6_fe_id", 64'(fe_warp_id_o), 64'd0);
    chk("t6_active", 64'(warp_active_o), 64'h00);
    chk("t6_lready", 64'(launch_ready_o), 64'd1);
    chk("t6_all_idle", 64'(all_idle_o), 64'd1);
    ic_ready_i = 1'b1;
    dec_decoded_i = 1'b1;
    dec_decoded_warp_id_i = 3'd1;
    dec_decoded_next_pc_i = 32'h999;
    tick();
    dec_decoded_i = 1'b0;
    chk("t6_late_active", 64'(warp_active_o), 64'h00);
    tick();
    chk("t6_late_vld", 64'(fe_valid_o), 64'd0);
    chk("t6_late_idle", 64'(all_idle_o), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
